// File: rtl/servo_pkg.sv
// Constants and types shared by the servo PWM generator and decoder:
// direction codes, nominal pulse widths, tolerances and FSM state encoding.
package servo_pkg;

  typedef enum logic [2:0] {
    STRAIGHT    = 3'b000,
    LEFT_SMALL  = 3'b001,
    LEFT_BIG    = 3'b011,
    RIGHT_SMALL = 3'b101,
    RIGHT_BIG   = 3'b111
  } dir_t;

  localparam int unsigned NOM_LEFT_BIG    = 1000;
  localparam int unsigned NOM_LEFT_SMALL  = 1250;
  localparam int unsigned NOM_STRAIGHT    = 1500;
  localparam int unsigned NOM_RIGHT_SMALL = 1750;
  localparam int unsigned NOM_RIGHT_BIG   = 2000;
  localparam int unsigned TOL_US          = 100;
  localparam int unsigned WMAX_US         = 2500;
  localparam int unsigned TIMEOUT_US      = 15000;
  localparam int unsigned PERIOD_US       = 5000;

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2
  } dec_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the servo line plus rise/fall detection.
// ready gates the edge strobes until the chain holds genuinely sampled data.
module pwm_sync_edge (
  input  logic clkus,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic ready
);

  logic [2:0] sync_reg;
  logic [2:0] fill_reg;

  always_ff @(posedge clkus) begin
    if (rst) begin
      sync_reg <= 3'b000;
      fill_reg <= 3'b000;
    end else begin
      sync_reg <= {sync_reg[1:0], pwm_in};
      fill_reg <= {fill_reg[1:0], 1'b1};
    end
  end

  // sync_reg[1] is s2 (synchronized level), sync_reg[2] is s3 (previous s2)
  assign level = sync_reg[1];
  assign ready = fill_reg[2];
  assign rise  = ready & sync_reg[1] & ~sync_reg[2];
  assign fall  = ready & ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures servo PWM high time in microseconds and decodes it back to the
// front-wheel direction code, with overlength, bad-code and loss supervision.
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int unsigned W_LEFT_BIG    = NOM_LEFT_BIG,
  parameter int unsigned W_LEFT_SMALL  = NOM_LEFT_SMALL,
  parameter int unsigned W_STRAIGHT    = NOM_STRAIGHT,
  parameter int unsigned W_RIGHT_SMALL = NOM_RIGHT_SMALL,
  parameter int unsigned W_RIGHT_BIG   = NOM_RIGHT_BIG,
  parameter int unsigned TOL           = TOL_US,
  parameter int unsigned W_MAX         = WMAX_US,
  parameter int unsigned TIMEOUT       = TIMEOUT_US
) (
  input  logic        clkus,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [2:0]  direction,
  output logic [15:0] width,
  output logic        valid,
  output logic        err_code,
  output logic        err_width,
  output logic        lost
);

  localparam int unsigned NOMS [5] = '{W_LEFT_BIG, W_LEFT_SMALL, W_STRAIGHT,
                                       W_RIGHT_SMALL, W_RIGHT_BIG};
  localparam dir_t CODES [5] = '{LEFT_BIG, LEFT_SMALL, STRAIGHT,
                                 RIGHT_SMALL, RIGHT_BIG};

  logic s2, rise, fall, ready;
  dec_state_t state_reg, state_next;
  logic [15:0] hcnt_reg, pcnt_reg, width_reg;
  logic [2:0]  dir_reg;
  logic        valid_reg, err_code_reg, err_width_reg, lost_reg, dec_pend_reg;
  logic        hcnt_load, hcnt_inc, capture, overflow, timeout;
  logic [4:0]  hit;
  logic        dec_hit;
  dir_t        dec_code;

  pwm_sync_edge u_sync (
    .clkus  (clkus),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (s2),
    .rise   (rise),
    .fall   (fall),
    .ready  (ready)
  );

  always_ff @(posedge clkus) begin
    if (rst) state_reg <= ARM;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARM:       if (ready && !s2) state_next = WAIT_RISE;
      WAIT_RISE: if (rise) state_next = HIGH;
      HIGH: begin
        if (fall)                         state_next = WAIT_RISE;
        else if (hcnt_reg == 16'(W_MAX))  state_next = ARM;
      end
      default:   state_next = ARM;
    endcase
  end

  always_comb begin
    hcnt_load = 1'b0;
    hcnt_inc  = 1'b0;
    capture   = 1'b0;
    overflow  = 1'b0;
    case (state_reg)
      WAIT_RISE: hcnt_load = rise;
      HIGH: begin
        capture  = fall;
        hcnt_inc = !fall;
        overflow = !fall && (hcnt_reg == 16'(W_MAX));
      end
      default: ;
    endcase
  end

  // Unsigned window compares; the lower bound clamps at zero for tiny nominals
  for (genvar gi = 0; gi < 5; gi++) begin : g_win
    localparam int unsigned LO = (NOMS[gi] > TOL) ? NOMS[gi] - TOL : 0;
    localparam int unsigned HI = NOMS[gi] + TOL;
    assign hit[gi] = (32'(width_reg) >= LO) && (32'(width_reg) <= HI);
  end

  // Scan from the back so the lowest-index (first listed) window wins
  always_comb begin
    dec_hit  = 1'b0;
    dec_code = STRAIGHT;
    for (int i = 4; i >= 0; i--) begin
      if (hit[i]) begin
        dec_hit  = 1'b1;
        dec_code = CODES[i];
      end
    end
  end

  assign timeout = !rise && (pcnt_reg == 16'(TIMEOUT));

  always_ff @(posedge clkus) begin
    if (rst) begin
      hcnt_reg      <= 16'd0;
      pcnt_reg      <= 16'd0;
      width_reg     <= 16'd0;
      dir_reg       <= STRAIGHT;
      valid_reg     <= 1'b0;
      err_code_reg  <= 1'b0;
      err_width_reg <= 1'b0;
      lost_reg      <= 1'b0;
      dec_pend_reg  <= 1'b0;
    end else begin
      if (hcnt_load)                        hcnt_reg <= 16'd1;
      else if (hcnt_inc && ~&hcnt_reg)      hcnt_reg <= hcnt_reg + 16'd1;
      if (rise)                             pcnt_reg <= 16'd1;
      else if (~&pcnt_reg)                  pcnt_reg <= pcnt_reg + 16'd1;
      if (capture)                          width_reg <= hcnt_reg;
      dec_pend_reg  <= capture;
      valid_reg     <= dec_pend_reg && dec_hit;
      err_code_reg  <= dec_pend_reg && !dec_hit;
      err_width_reg <= overflow;
      if (dec_pend_reg && dec_hit) begin
        dir_reg  <= dec_code;
        lost_reg <= 1'b0;
      end else if (timeout) begin
        dir_reg  <= STRAIGHT;
        lost_reg <= 1'b1;
      end
    end
  end

  assign direction = dir_reg;
  assign width     = width_reg;
  assign valid     = valid_reg;
  assign err_code  = err_code_reg;
  assign err_width = err_width_reg;
  assign lost      = lost_reg;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder: hand-derived widths, codes, strobe
// counts and latencies (in clkus edges) checked with immediate assertions.
module tb_servo_pwm_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [2:0]  direction;
  logic [15:0] width;
  logic        valid, err_code, err_width, lost;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int n_valid = 0, n_errc = 0, n_errw = 0, n_multi = 0;
  int valid_at = 0, errc_at = 0, errw_at = 0, lost_at = 0;
  logic lost_q = 1'b0;
  int rise_c, fall_c;
  int v0, c0, w0;

  servo_pwm_decoder dut (
    .clkus     (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .direction (direction),
    .width     (width),
    .valid     (valid),
    .err_code  (err_code),
    .err_width (err_width),
    .lost      (lost)
  );

  always #500 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    lost_q <= lost;
    if (valid)     begin n_valid <= n_valid + 1; valid_at <= cyc; end
    if (err_code)  begin n_errc  <= n_errc + 1;  errc_at  <= cyc; end
    if (err_width) begin n_errw  <= n_errw + 1;  errw_at  <= cyc; end
    if (int'(valid) + int'(err_code) + int'(err_width) > 1) n_multi <= n_multi + 1;
    if (lost && !lost_q) lost_at <= cyc;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_vec++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Called at a negedge: drives hi us high then lo us low
  task automatic pulse(input int hi, input int lo);
    pwm_in = 1'b1;
    rise_c = cyc;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    fall_c = cyc;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dir", direction, 0);
    chk("rst_width", width, 0);
    chk("rst_strobes", {valid, err_code, err_width}, 0);
    chk("rst_lost", lost, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Three STRAIGHT frames at the 5 ms period
    v0 = n_valid; c0 = n_errc; w0 = n_errw;
    repeat (3) pulse(1500, 3500);
    chk("straight_valid_cnt", n_valid - v0, 3);
    chk("straight_dir", direction, 0);
    chk_rng("straight_width", width, 1499, 1501);
    chk("straight_no_err", (n_errc - c0) + (n_errw - w0), 0);
    chk("straight_latency", valid_at - fall_c, 4);

    // RIGHT_BIG then LEFT_BIG
    v0 = n_valid;
    pulse(2000, 2000);
    chk("rbig_valid_cnt", n_valid - v0, 1);
    chk("rbig_dir", direction, 7);
    chk_rng("rbig_width", width, 1999, 2001);
    chk("rbig_latency", valid_at - fall_c, 4);
    pulse(1000, 2000);
    chk("lbig_valid_cnt", n_valid - v0, 2);
    chk("lbig_dir", direction, 3);
    chk("lbig_latency", valid_at - fall_c, 4);

    // 1620 us lies between the STRAIGHT and RIGHT_SMALL windows
    pulse(1500, 2000);
    chk("pre_gap_dir", direction, 0);
    v0 = n_valid; c0 = n_errc;
    pulse(1620, 2000);
    chk("gap_errc_cnt", n_errc - c0, 1);
    chk("gap_no_valid", n_valid - v0, 0);
    chk("gap_dir_held", direction, 0);
    chk("gap_errc_latency", errc_at - fall_c, 4);
    chk_rng("gap_width", width, 1619, 1621);

    // Overlong high time, then LEFT_SMALL
    v0 = n_valid; c0 = n_errc; w0 = n_errw;
    pulse(3000, 2000);
    chk("long_errw_cnt", n_errw - w0, 1);
    chk("long_errw_at_2501", errw_at - rise_c, 2503);
    chk("long_no_other", (n_valid - v0) + (n_errc - c0), 0);
    chk_rng("long_width_held", width, 1619, 1621);
    chk("long_dir_held", direction, 0);
    pulse(1250, 2000);
    chk("lsmall_valid_cnt", n_valid - v0, 1);
    chk("lsmall_dir", direction, 1);

    // RIGHT_SMALL, then idle until signal loss
    v0 = n_valid;
    pulse(1750, 10);
    c0 = rise_c;
    chk("rsmall_dir", direction, 5);
    chk("rsmall_lost_clear", lost, 0);
    while (cyc < c0 + 15010) @(negedge clk);
    chk("lost_set", lost, 1);
    chk("lost_timing", lost_at - c0, 15003);
    chk("lost_failsafe_dir", direction, 0);
    pulse(1750, 2000);
    chk("recover_lost", lost, 0);
    chk("recover_valid_cnt", n_valid - v0, 2);
    chk("recover_dir", direction, 5);

    // Reset in the middle of a pulse
    pwm_in = 1'b1;
    repeat (750) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_dir", direction, 0);
    chk("midrst_width", width, 0);
    chk("midrst_strobes", {valid, err_code, err_width}, 0);
    chk("midrst_lost", lost, 0);
    rst = 1'b0;
    v0 = n_valid; c0 = n_errc; w0 = n_errw;
    repeat (750) @(negedge clk);
    pwm_in = 1'b0;
    repeat (2000) @(negedge clk);
    chk("midrst_no_strobe", (n_valid - v0) + (n_errc - c0) + (n_errw - w0), 0);
    chk("midrst_width_still0", width, 0);
    pulse(2000, 2000);
    chk("post_rst_valid_cnt", n_valid - v0, 1);
    chk("post_rst_dir", direction, 7);
    chk_rng("post_rst_width", width, 1999, 2001);

    chk("strobes_exclusive", n_multi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
